exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage between the ID/EXE pipeline register and the memory stage.
- Takes the registered decode outputs, selects ALU operands (with forwarding), computes the result, and maintains the zero flag.
- Resolves beq/bne/jump, drives a one-shot PC redirect plus a flush to the front end, and registers results into the EXE/MEM pipeline register with stall and squash support.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_UNUSED_ZERO, 0, value loaded into every registered output on reset.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- exe_a, exe_b, exe_imm  in  XLEN each  register operands and sign-extended immediate.
- exe_pc  in  XLEN  address of the instruction in EXE.
- exe_rn  in  5  destination register.
- exe_aluc  in  3  ALU op.
- exe_alu_a_select, exe_alu_b_select  in  2 each  operand selects.
- exe_wreg, exe_m2reg, exe_wmem, exe_wz  in  1 each  control bits.
- exe_is_beq, exe_is_bne, exe_is_jump  in  1 each  control-flow type.
- fwd_mem, fwd_wb  in  XLEN each  forwarded results from MEM and WB.
- stall  in  1  hold EXE and the EXE/MEM register.
- redirect  out  1  PC redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- flush  out  1  kill IF/ID and ID/EXE; equals redirect.
- z_flag  out  1  stored zero flag.
- mem_alu, mem_b  out  XLEN each  registered ALU result and store data.
- mem_rn  out  5  registered destination.
- mem_wreg, mem_m2reg, mem_wmem  out  1 each  registered controls.

Behaviour:
- Reset (clr=1, asynchronous): z_flag, redirect_done, mem_alu, mem_b, mem_rn, mem_wreg, mem_m2reg and mem_wmem all go to 0. redirect and flush read 0 while clr is high.
- Operand A select: 0 = exe_a; 1 = zero-extended exe_imm[10:6] (shamt); 2 = fwd_mem; 3 = fwd_wb.
- Operand B select: 0 = exe_b; 1 = exe_imm; 2 = fwd_mem; 3 = fwd_wb. mem_b always takes raw exe_b.
- ALU ops (exe_aluc):
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 sll: B << A[4:0].
  - 110 srl: B >> A[4:0], logical.
  - 111 slt: signed, result 1 or 0.
  - Arithmetic is modulo 2^XLEN; no overflow trap.
- Zero: zero_now = (alu == 0).
  - On a clock edge with exe_wz=1 and stall=0, z_flag <= zero_now; otherwise z_flag holds.
- Branch condition: zsrc = zero_now if exe_wz=1 (bypass), else the stored z_flag.
  - take = exe_is_jump | (exe_is_beq & zsrc) | (exe_is_bne & ~zsrc).
  - More than one of is_beq/is_bne/is_jump set at once: jump wins; the bench never drives both beq and bne.
- Targets:
  - beq/bne: exe_pc + 4 + (exe_imm << 2).
  - jump: {exe_pc[31:28], exe_imm[25:0], 2'b00}, computed on pc+4's upper bits per MIPS.
- Redirect is combinational in the EXE cycle: redirect = take & ~redirect_done.
  - redirect_done is set at the clock edge where redirect=1 and stall=1.
  - redirect_done clears at any edge with stall=0.
  - Result: redirect pulses exactly once per instruction, even across multi-cycle stalls.
- EXE/MEM register, at the clock edge:
  - stall=1: all mem_* hold.
  - else: mem_alu <= alu, mem_b <= exe_b, mem_rn <= exe_rn, and mem_wreg/mem_m2reg/mem_wmem <= the exe_* controls.
  - Branches and jumps carry wreg=0/wmem=0 from decode; the stage adds no extra gating.
- Latency: ALU result appears on mem_* 1 cycle after the instruction is in EXE; redirect has 0 cycles of latency.
- Reset mid-stall clears redirect_done, so a re-presented branch redirects again.

Decomposition:
- Shared package cpu_defs holds:
  - ALU opcode constants (ALU_ADD .. ALU_SLT).
  - Operand-select constants (SEL_REG, SEL_SHAMT/SEL_IMM, SEL_FMEM, SEL_FWB).
- One sub-module, exe_alu: purely combinational; inputs a, b, aluc; outputs result and zero.
- exe_stage instantiates exe_alu and holds all state: z_flag, redirect_done and the EXE/MEM register.

Test Plan:
- Reset: assert clr mid-cycle with mem_* nonzero -> all mem_* and z_flag are 0 immediately, and redirect=0.
- ALU/forwarding: a=5, b=7, aluc=001, b_select=2, fwd_mem=5, wz=1 -> mem_alu=0 next edge and z_flag=1. Then slt with a=0xFFFFFFFF, b=1 -> mem_alu=1.
- beq bypass: exe_pc=0x100, imm=3, aluc=sub, a=b=9, wz=1, is_beq=1 -> redirect=1 and redirect_pc=0x110 in the same cycle.
- bne from stored flag: prior op leaves z_flag=0; bne with wz=0, imm=0xFFFFFFFE, pc=0x200 -> redirect=1 and redirect_pc=0x1FC.
- Stall one-shot: taken jump (imm=0x40, pc=0x10000000) held with stall=1 for 3 cycles -> redirect high only in cycle 1 with target 0x10000100. mem_* and z_flag hold; after stall drops, the next taken branch redirects again.
- Not taken: beq with z=0 -> redirect=0, flush=0, and mem_wreg follows exe_wreg=0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared execute-stage definitions: ALU opcodes, operand selects and small typedefs.
package cpu_defs;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // SEL_SHAMT applies to operand A, SEL_IMM to operand B; they share an encoding.
  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_SHAMT = 2'd1;
  localparam logic [1:0] SEL_IMM   = 2'd1;
  localparam logic [1:0] SEL_FMEM  = 2'd2;
  localparam logic [1:0] SEL_FWB   = 2'd3;

  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
  } mem_ctl_t;

  typedef enum logic {
    StArmed,
    StFired
  } redirect_state_e;

endpackage

// File: rtl/exe_stage_if.sv
// Bundle of ID/EXE inputs, forwarding paths, stall and the EXE/MEM / redirect outputs.
interface exe_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] exe_a;
  logic [XLEN-1:0] exe_b;
  logic [XLEN-1:0] exe_imm;
  logic [XLEN-1:0] exe_pc;
  logic [4:0]      exe_rn;
  logic [2:0]      exe_aluc;
  logic [1:0]      exe_alu_a_select;
  logic [1:0]      exe_alu_b_select;
  logic            exe_wreg;
  logic            exe_m2reg;
  logic            exe_wmem;
  logic            exe_wz;
  logic            exe_is_beq;
  logic            exe_is_bne;
  logic            exe_is_jump;
  logic [XLEN-1:0] fwd_mem;
  logic [XLEN-1:0] fwd_wb;
  logic            stall;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            z_flag;
  logic [XLEN-1:0] mem_alu;
  logic [XLEN-1:0] mem_b;
  logic [4:0]      mem_rn;
  logic            mem_wreg;
  logic            mem_m2reg;
  logic            mem_wmem;

  modport master (
    output exe_a, exe_b, exe_imm, exe_pc, exe_rn, exe_aluc,
    output exe_alu_a_select, exe_alu_b_select,
    output exe_wreg, exe_m2reg, exe_wmem, exe_wz,
    output exe_is_beq, exe_is_bne, exe_is_jump,
    output fwd_mem, fwd_wb, stall,
    input  redirect, redirect_pc, flush, z_flag,
    input  mem_alu, mem_b, mem_rn, mem_wreg, mem_m2reg, mem_wmem
  );

  modport slave (
    input  exe_a, exe_b, exe_imm, exe_pc, exe_rn, exe_aluc,
    input  exe_alu_a_select, exe_alu_b_select,
    input  exe_wreg, exe_m2reg, exe_wmem, exe_wz,
    input  exe_is_beq, exe_is_bne, exe_is_jump,
    input  fwd_mem, fwd_wb, stall,
    output redirect, redirect_pc, flush, z_flag,
    output mem_alu, mem_b, mem_rn, mem_wreg, mem_m2reg, mem_wmem
  );
endinterface

// File: rtl/exe_alu.sv
// Combinational execute ALU: eight operations plus a zero detect on the result.
module exe_alu
  import cpu_defs::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      aluc_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic [4:0] shamt;
  logic       less;

  assign shamt = a_i[4:0];
  assign less  = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    unique case (aluc_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = b_i << shamt;
      ALU_SRL: result_o = b_i >> shamt;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, less};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, zero flag, branch/jump resolution with a
// one-shot redirect, and the EXE/MEM pipeline register.
module exe_stage
  import cpu_defs::*;
#(
  parameter int unsigned XLEN                 = 32,
  parameter int unsigned RESET_PC_UNUSED_ZERO = 0
) (
  input logic        clk,
  input logic        clr,
  exe_stage_if.slave exe_io
);

  localparam logic [XLEN-1:0] RstWord = XLEN'(RESET_PC_UNUSED_ZERO);

  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic            zero_now, zsrc, take, redirect;
  logic [XLEN-1:0] pc_plus4, br_target, jmp_target;

  logic            z_flag_q, z_flag_d;
  redirect_state_e rd_state_q, rd_state_d;
  logic [XLEN-1:0] mem_alu_q, mem_alu_d;
  logic [XLEN-1:0] mem_b_q, mem_b_d;
  logic [4:0]      mem_rn_q, mem_rn_d;
  mem_ctl_t        mem_ctl_q, mem_ctl_d;

  always_comb begin
    op_a = exe_io.exe_a;
    unique case (exe_io.exe_alu_a_select)
      SEL_REG:   op_a = exe_io.exe_a;
      SEL_SHAMT: op_a = {{(XLEN-5){1'b0}}, exe_io.exe_imm[10:6]};
      SEL_FMEM:  op_a = exe_io.fwd_mem;
      SEL_FWB:   op_a = exe_io.fwd_wb;
      default:   op_a = exe_io.exe_a;
    endcase
  end

  always_comb begin
    op_b = exe_io.exe_b;
    unique case (exe_io.exe_alu_b_select)
      SEL_REG:  op_b = exe_io.exe_b;
      SEL_IMM:  op_b = exe_io.exe_imm;
      SEL_FMEM: op_b = exe_io.fwd_mem;
      SEL_FWB:  op_b = exe_io.fwd_wb;
      default:  op_b = exe_io.exe_b;
    endcase
  end

  exe_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a_i     (op_a),
    .b_i     (op_b),
    .aluc_i  (exe_io.exe_aluc),
    .result_o(alu_res),
    .zero_o  (zero_now)
  );

  // A compare that also writes the flag resolves against its own fresh result.
  assign zsrc = exe_io.exe_wz ? zero_now : z_flag_q;
  assign take = exe_io.exe_is_jump | (exe_io.exe_is_beq & zsrc) | (exe_io.exe_is_bne & ~zsrc);

  assign pc_plus4   = exe_io.exe_pc + XLEN'(4);
  assign br_target  = pc_plus4 + (exe_io.exe_imm << 2);
  assign jmp_target = {pc_plus4[XLEN-1:28], exe_io.exe_imm[25:0], 2'b00};

  // Redirect state: remembers that this stalled instruction already redirected.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_state_q <= StArmed;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    if (!exe_io.stall) begin
      rd_state_d = StArmed;
    end else if (redirect) begin
      rd_state_d = StFired;
    end
  end

  always_comb begin
    redirect = take & (rd_state_q == StArmed) & ~clr;
  end

  always_comb begin
    z_flag_d  = z_flag_q;
    mem_alu_d = mem_alu_q;
    mem_b_d   = mem_b_q;
    mem_rn_d  = mem_rn_q;
    mem_ctl_d = mem_ctl_q;
    if (!exe_io.stall) begin
      if (exe_io.exe_wz) begin
        z_flag_d = zero_now;
      end
      mem_alu_d = alu_res;
      mem_b_d   = exe_io.exe_b;
      mem_rn_d  = exe_io.exe_rn;
      mem_ctl_d = '{wreg: exe_io.exe_wreg, m2reg: exe_io.exe_m2reg, wmem: exe_io.exe_wmem};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_flag_q  <= RstWord[0];
      mem_alu_q <= RstWord;
      mem_b_q   <= RstWord;
      mem_rn_q  <= RstWord[4:0];
      mem_ctl_q <= '{wreg: RstWord[0], m2reg: RstWord[0], wmem: RstWord[0]};
    end else begin
      z_flag_q  <= z_flag_d;
      mem_alu_q <= mem_alu_d;
      mem_b_q   <= mem_b_d;
      mem_rn_q  <= mem_rn_d;
      mem_ctl_q <= mem_ctl_d;
    end
  end

  assign exe_io.redirect    = redirect;
  assign exe_io.flush       = redirect;
  assign exe_io.redirect_pc = exe_io.exe_is_jump ? jmp_target : br_target;
  assign exe_io.z_flag      = z_flag_q;
  assign exe_io.mem_alu     = mem_alu_q;
  assign exe_io.mem_b       = mem_b_q;
  assign exe_io.mem_rn      = mem_rn_q;
  assign exe_io.mem_wreg    = mem_ctl_q.wreg;
  assign exe_io.mem_m2reg   = mem_ctl_q.m2reg;
  assign exe_io.mem_wmem    = mem_ctl_q.wmem;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_exe_stage;
  import cpu_defs::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic clr = 1'b1;

  exe_stage_if #(.XLEN(XLEN)) bus ();

  exe_stage #(
    .XLEN                (XLEN),
    .RESET_PC_UNUSED_ZERO(0)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .exe_io(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: stored flag, "already redirected while stalled", EXE/MEM contents.
  logic        m_z, m_done;
  logic [31:0] m_alu, m_b;
  logic [4:0]  m_rn;
  logic        m_wreg, m_m2reg, m_wmem;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu();
    logic [31:0] ops_a[4];
    logic [31:0] ops_b[4];
    logic [31:0] a, b, r;
    ops_a[0] = bus.exe_a;
    ops_a[1] = 32'(bus.exe_imm[10:6]);
    ops_a[2] = bus.fwd_mem;
    ops_a[3] = bus.fwd_wb;
    ops_b[0] = bus.exe_b;
    ops_b[1] = bus.exe_imm;
    ops_b[2] = bus.fwd_mem;
    ops_b[3] = bus.fwd_wb;
    a = ops_a[bus.exe_alu_a_select];
    b = ops_b[bus.exe_alu_b_select];
    case (bus.exe_aluc)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = b << a[4:0];
      3'd6:    r = b >> a[4:0];
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_take();
    logic zs;
    zs = bus.exe_wz ? (ref_alu() == 32'd0) : m_z;
    return bus.exe_is_jump | (bus.exe_is_beq & zs) | (bus.exe_is_bne & ~zs);
  endfunction

  function automatic logic [31:0] ref_target();
    logic [31:0] pc4;
    pc4 = bus.exe_pc + 32'd4;
    if (bus.exe_is_jump) return {pc4[31:28], bus.exe_imm[25:0], 2'b00};
    return pc4 + bus.exe_imm * 32'd4;
  endfunction

  task automatic model_update();
    logic [31:0] r;
    logic        red;
    if (clr) begin
      m_z = 0; m_done = 0; m_alu = 0; m_b = 0; m_rn = 0;
      m_wreg = 0; m_m2reg = 0; m_wmem = 0;
    end else begin
      r   = ref_alu();
      red = ref_take() && !m_done;
      if (!bus.stall) begin
        if (bus.exe_wz) m_z = (r == 32'd0);
        m_done  = 0;
        m_alu   = r;
        m_b     = bus.exe_b;
        m_rn    = bus.exe_rn;
        m_wreg  = bus.exe_wreg;
        m_m2reg = bus.exe_m2reg;
        m_wmem  = bus.exe_wmem;
      end else if (red) begin
        m_done = 1;
      end
    end
  endtask

  initial begin
    model_update();
    forever begin
      @(posedge clk or posedge clr);
      model_update();
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    logic exp_red;
    forever begin
      @(negedge clk);
      if (clr) begin
        check("cmp_redirect_in_reset", bus.redirect, 0);
        check("cmp_flush_in_reset", bus.flush, 0);
      end else begin
        exp_red = ref_take() && !m_done;
        check("cmp_redirect", bus.redirect, exp_red);
        check("cmp_flush", bus.flush, exp_red);
        if (ref_take()) check("cmp_redirect_pc", bus.redirect_pc, ref_target());
      end
      check("cmp_z_flag", bus.z_flag, m_z);
      check("cmp_mem_alu", bus.mem_alu, m_alu);
      check("cmp_mem_b", bus.mem_b, m_b);
      check("cmp_mem_rn", bus.mem_rn, m_rn);
      check("cmp_mem_ctl", {bus.mem_wreg, bus.mem_m2reg, bus.mem_wmem},
            {m_wreg, m_m2reg, m_wmem});
    end
  end

  task automatic nop();
    bus.exe_a = 0; bus.exe_b = 0; bus.exe_imm = 0; bus.exe_pc = 0; bus.exe_rn = 0;
    bus.exe_aluc = ALU_ADD; bus.exe_alu_a_select = SEL_REG; bus.exe_alu_b_select = SEL_REG;
    bus.exe_wreg = 0; bus.exe_m2reg = 0; bus.exe_wmem = 0; bus.exe_wz = 0;
    bus.exe_is_beq = 0; bus.exe_is_bne = 0; bus.exe_is_jump = 0;
    bus.fwd_mem = 0; bus.fwd_wb = 0; bus.stall = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_instr();
    int k;
    bus.exe_a = $urandom;
    bus.exe_b = ($urandom_range(0, 3) == 0) ? bus.exe_a : $urandom;
    bus.exe_imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
    bus.exe_pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    bus.exe_rn = 5'($urandom_range(0, 31));
    bus.exe_aluc = 3'($urandom_range(0, 7));
    bus.exe_alu_a_select = 2'($urandom_range(0, 3));
    bus.exe_alu_b_select = 2'($urandom_range(0, 3));
    bus.fwd_mem = ($urandom_range(0, 1) == 0) ? bus.exe_a : $urandom;
    bus.fwd_wb = ($urandom_range(0, 1) == 0) ? bus.exe_b : $urandom;
    bus.exe_wreg = 1'($urandom_range(0, 1));
    bus.exe_m2reg = 1'($urandom_range(0, 1));
    bus.exe_wmem = 1'($urandom_range(0, 1));
    bus.exe_wz = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 4);
    bus.exe_is_beq = (k == 1) || (k == 4);
    bus.exe_is_bne = (k == 2);
    bus.exe_is_jump = (k == 3) || (k == 4);
  endtask

  initial begin
    logic hold;
    nop();
    clr = 1;
    bus.exe_is_jump = 1;
    bus.exe_imm = 32'h40;
    mid();
    check("rst_redirect", bus.redirect, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_mem_alu", bus.mem_alu, 0);
    check("rst_z_flag", bus.z_flag, 0);
    next();
    clr = 0;

    // Subtract with B forwarded from MEM: 5 - 5 = 0 sets the flag.
    nop();
    bus.exe_a = 5; bus.exe_b = 7; bus.exe_aluc = ALU_SUB; bus.exe_alu_b_select = SEL_FMEM;
    bus.fwd_mem = 5; bus.exe_wz = 1; bus.exe_wreg = 1; bus.exe_rn = 3;
    next();
    check("fwd_sub_mem_alu", bus.mem_alu, 0);
    check("fwd_sub_z_flag", bus.z_flag, 1);
    check("fwd_sub_mem_b", bus.mem_b, 7);
    check("fwd_sub_mem_rn", bus.mem_rn, 3);
    check("fwd_sub_mem_wreg", bus.mem_wreg, 1);

    nop();
    bus.exe_a = 32'hffff_ffff; bus.exe_b = 1; bus.exe_aluc = ALU_SLT; bus.exe_wreg = 1;
    next();
    check("slt_mem_alu", bus.mem_alu, 1);
    check("slt_z_hold", bus.z_flag, 1);

    // beq resolved on the bypassed zero of its own compare.
    nop();
    bus.exe_pc = 32'h100; bus.exe_imm = 3; bus.exe_aluc = ALU_SUB;
    bus.exe_a = 9; bus.exe_b = 9; bus.exe_wz = 1; bus.exe_is_beq = 1;
    mid();
    check("beq_redirect", bus.redirect, 1);
    check("beq_flush", bus.flush, 1);
    check("beq_target", bus.redirect_pc, 32'h110);
    next();

    nop();
    bus.exe_a = 1; bus.exe_b = 1; bus.exe_wz = 1;
    next();
    check("clear_z_flag", bus.z_flag, 0);

    nop();
    bus.exe_pc = 32'h200; bus.exe_imm = 32'hffff_fffe; bus.exe_is_bne = 1;
    bus.exe_a = 2; bus.exe_b = 3;
    mid();
    check("bne_redirect", bus.redirect, 1);
    check("bne_target", bus.redirect_pc, 32'h1fc);
    next();
    check("bne_mem_alu", bus.mem_alu, 5);

    // Jump held by a three-cycle stall: redirect only in the first cycle.
    nop();
    bus.exe_pc = 32'h1000_0000; bus.exe_imm = 32'h40; bus.exe_is_jump = 1;
    bus.exe_a = 32'h10; bus.exe_b = 32'h20; bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("stall_redirect", bus.redirect, (i == 0) ? 1 : 0);
      if (i == 0) check("jump_target", bus.redirect_pc, 32'h1000_0100);
      check("stall_mem_alu_hold", bus.mem_alu, 5);
      check("stall_z_hold", bus.z_flag, 0);
      next();
    end
    bus.stall = 0;
    mid();
    check("unstall_no_repeat", bus.redirect, 0);
    next();
    check("unstall_mem_alu", bus.mem_alu, 32'h30);

    nop();
    bus.exe_pc = 32'h300; bus.exe_imm = 1; bus.exe_is_bne = 1;
    mid();
    check("rearm_redirect", bus.redirect, 1);
    check("rearm_target", bus.redirect_pc, 32'h308);
    next();

    nop();
    bus.exe_a = 1; bus.exe_b = 2; bus.exe_wz = 1; bus.exe_wreg = 1;
    next();
    check("add_mem_wreg", bus.mem_wreg, 1);
    check("add_z_flag", bus.z_flag, 0);

    nop();
    bus.exe_is_beq = 1; bus.exe_a = 4; bus.exe_b = 4;
    mid();
    check("nt_redirect", bus.redirect, 0);
    check("nt_flush", bus.flush, 0);
    next();
    check("nt_mem_wreg", bus.mem_wreg, 0);
    check("nt_mem_alu", bus.mem_alu, 8);

    // Reset in the middle of a stalled jump re-arms the redirect.
    nop();
    bus.exe_pc = 32'h1000_0000; bus.exe_imm = 32'h40; bus.exe_is_jump = 1; bus.stall = 1;
    mid();
    check("rst_stall_first", bus.redirect, 1);
    next();
    mid();
    check("rst_stall_second", bus.redirect, 0);
    #1 clr = 1;
    #1;
    check("midrst_mem_alu", bus.mem_alu, 0);
    check("midrst_z_flag", bus.z_flag, 0);
    check("midrst_redirect", bus.redirect, 0);
    check("midrst_mem_wreg", bus.mem_wreg, 0);
    #1 clr = 0;
    #1;
    check("postrst_redirect", bus.redirect, 1);
    next();
    bus.stall = 0;

    // Randomized traffic; a stalled instruction stays presented until released.
    hold = 0;
    repeat (600) begin
      next();
      if (clr) clr = 0;
      else if ($urandom_range(0, 99) == 0) clr = 1;
      if (!hold) rand_instr();
      bus.stall = ($urandom_range(0, 3) == 0);
      hold = bus.stall;
    end
    next();
    clr = 0;
    nop();
    repeat (2) next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
